// File: rtl/decode_stage.sv
// Decode stage: splits a raw RV instruction into format, immediate and resolved operands,
// and holds the result in a single ID/EX register toward execute.
module decode_stage #(
    parameter int XLEN    = 64,
    parameter int NUM_FWD = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         in_pc,
    input  logic [31:0]             in_instr,
    output logic [4:0]              ra1,
    output logic [4:0]              ra2,
    input  logic [XLEN-1:0]         rd1,
    input  logic [XLEN-1:0]         rd2,
    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [5*NUM_FWD-1:0]    fwd_addr,
    input  logic [XLEN*NUM_FWD-1:0] fwd_data,
    input  logic                    ex_is_load,
    input  logic [4:0]              ex_rd,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_pc,
    output logic [XLEN-1:0]         out_srca,
    output logic [XLEN-1:0]         out_srcb,
    output logic [XLEN-1:0]         out_imm,
    output logic [4:0]              out_rd,
    output logic [4:0]              out_rs1,
    output logic [4:0]              out_rs2,
    output logic [2:0]              out_fmt
);

    // Handshake: a transfer happens on an edge where the producer's valid and the
    // consumer's ready are both high; valid never depends on ready combinationally.
    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmtE;

    fmtE              fmt;
    logic [31:0]      imm32;
    logic [XLEN-1:0]  immX;
    logic [XLEN-1:0]  srcA;
    logic [XLEN-1:0]  srcB;
    logic             usesRs2;
    logic             hazard;
    logic             regFree;
    logic             accept;

    assign ra1 = in_instr[19:15];
    assign ra2 = in_instr[24:20];

    always_comb begin
        fmt = FMT_ILL;
        case (in_instr[6:0])
            7'b0110011, 7'b0111011:                         fmt = FMT_R;
            7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111: fmt = FMT_I;
            7'b0100011:                                     fmt = FMT_S;
            7'b1100011:                                     fmt = FMT_B;
            7'b0110111, 7'b0010111:                         fmt = FMT_U;
            7'b1101111:                                     fmt = FMT_J;
            default:                                        fmt = FMT_ILL;
        endcase
    end

    always_comb begin
        imm32 = 32'd0;
        case (fmt)
            FMT_I: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_S: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U: imm32 = {in_instr[31:12], 12'd0};
            FMT_J: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
    end

    assign immX = XLEN'($signed(imm32));

    // Scan from the highest index down so the lowest-index matching source wins.
    function automatic logic [XLEN-1:0] resolveOperand(
        input logic [4:0]              addr,
        input logic [XLEN-1:0]         regData,
        input logic [NUM_FWD-1:0]      fv,
        input logic [5*NUM_FWD-1:0]    fa,
        input logic [XLEN*NUM_FWD-1:0] fd
    );
        logic [XLEN-1:0] r;
        r = regData;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fv[k] && (fa[5*k +: 5] == addr)) begin
                r = fd[XLEN*k +: XLEN];
            end
        end
        if (addr == 5'd0) begin
            r = '0;
        end
        return r;
    endfunction

    assign srcA = resolveOperand(ra1, rd1, fwd_valid, fwd_addr, fwd_data);
    assign srcB = resolveOperand(ra2, rd2, fwd_valid, fwd_addr, fwd_data);

    // rs2 is only a real source for formats that read two registers.
    assign usesRs2 = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
    assign hazard  = ex_is_load && (ex_rd != 5'd0) &&
                     ((ex_rd == ra1) || (usesRs2 && (ex_rd == ra2)));

    assign regFree  = !out_valid || out_ready;
    assign in_ready = regFree && !hazard && !flush && !reset;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_srca  <= '0;
            out_srcb  <= '0;
            out_imm   <= '0;
            out_rd    <= 5'd0;
            out_rs1   <= 5'd0;
            out_rs2   <= 5'd0;
            out_fmt   <= 3'd0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (regFree) begin
            // A free register with nothing accepted becomes a bubble; data fields keep old values.
            out_valid <= accept;
            if (accept) begin
                out_pc   <= in_pc;
                out_srca <= srcA;
                out_srcb <= srcB;
                out_imm  <= immX;
                out_rd   <= in_instr[11:7];
                out_rs1  <= ra1;
                out_rs2  <= ra2;
                out_fmt  <= fmt;
            end
        end
    end

endmodule
